div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have exactly these ports: I_clk, I_rst, I_start, I_op, I_data1, I_data2, O_busy, O_done, O_data.
REQ-002 I_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 I_rst  input  1  synchronous, active-high reset.
REQ-004 I_start  input  1  request pulse; sampled only when the block is not busy.
REQ-005 I_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M semantics).
REQ-006 I_data1  input  32  dividend (signed or unsigned per I_op).
REQ-007 I_data2  input  32  divisor (signed or unsigned per I_op).
REQ-008 O_busy  output  1  high while an operation is in progress (CALC or FIXUP).
REQ-009 O_done  output  1  single-cycle result-valid strobe.
REQ-010 O_data  output  32  quotient or remainder; held stable from O_done until the next accepted start.

Function
REQ-011 The block SHALL implement the FSM states IDLE, CALC, FIXUP and DONE, with all outputs registered.
REQ-012 IDLE or DONE with I_start=1 SHALL latch I_op, I_data1 and I_data2, load the iteration counter with 31, and go to CALC. Otherwise IDLE holds and DONE returns to IDLE.
REQ-013 I_start while O_busy=1 SHALL be ignored; operand changes during CALC/FIXUP SHALL NOT affect the result.
REQ-014 For signed ops (DIV, REM), CALC SHALL operate on the absolute values of the operands. The magnitude of -2^31 is taken as the unsigned value 0x80000000.
REQ-015 CALC SHALL perform one restoring shift-subtract step per cycle: 32 cycles in total, counter decrementing 31 to 0. It exits to FIXUP after the step at counter 0.
REQ-016 FIXUP SHALL select and correct the result, write it to O_data, and go to DONE:
- DIV quotient negated when the operand signs differ.
- REM remainder takes the sign of the dividend.
REQ-017 Divisor zero SHALL yield:
- DIV/DIVU: 0xFFFFFFFF.
- REM/REMU: the dividend unchanged.
REQ-018 Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF) SHALL yield 0x80000000 for DIV and 0x00000000 for REM.
REQ-019 O_done SHALL be 1 exactly when the state is DONE. Baseline latency: O_done is high in the cycle after the 33rd rising edge following the edge that accepted I_start.
REQ-020 A start accepted in DONE (back-to-back) SHALL deassert O_done on the next edge and begin the new operation with no idle cycle.

Reset
REQ-021 I_rst=1 at a rising edge SHALL force IDLE, O_busy=0, O_done=0, O_data=0x00000000, counter=0.
REQ-022 Reset mid-operation SHALL abort the operation without producing O_done. I_start is ignored in any cycle where I_rst=1.

Configuration
REQ-023 Macro DIV_EARLY_OUT_EN SHALL select the special-case latency.
REQ-024 With DIV_EARLY_OUT_EN defined, divisor-zero and signed-overflow cases SHALL bypass CALC/FIXUP: the accepting edge goes directly to DONE with the REQ-017/REQ-018 value in O_data, so O_done is high the very next cycle.
REQ-025 Without DIV_EARLY_OUT_EN, all operations SHALL take the full baseline latency of REQ-019. Result values SHALL be identical in both builds.

Verification
REQ-026 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> O_data 0xFFFFFFFD (-3), O_done at baseline latency. REM with the same operands -> 0xFFFFFFFF (-1).
REQ-027 DIVU 0xFFFFFFFF / 0x00000010 -> 0x0FFFFFFF. REMU with the same operands -> 0x0000000F.
REQ-028 DIV 0x00001234 / 0 -> 0xFFFFFFFF. REMU 0x00001234 / 0 -> 0x00001234. O_done after 1 cycle with DIV_EARLY_OUT_EN, at baseline latency without it.
REQ-029 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0x00000000.
REQ-030 Start DIVU 100/7, pulse I_rst at CALC cycle 10 -> no O_done, O_data 0, O_busy 0. A new start DIVU 100/7 -> 0x0000000E.
REQ-031 Start asserted in the DONE cycle with new operands -> second result correct, no idle gap. Mid-CALC I_start with operand changes -> first result unaffected.

Source files
------------

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): one restoring shift-subtract step per cycle.
// DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish on the accepting edge instead of running CALC.
module div_unit (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_start,
  input  logic [1:0]  I_op,
  input  logic [31:0] I_data1,
  input  logic [31:0] I_data2,
  output logic        O_busy,
  output logic        O_done,
  output logic [31:0] O_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        is_rem_q;
  logic        q_neg;
  logic        r_neg;
  logic        special_q;
  logic [31:0] special_val_q;

  logic        in_signed;
  logic        a_neg;
  logic        b_neg;
  logic        in_special;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] special_val;
  logic [32:0] rs;
  logic [32:0] diff;
  logic [31:0] result;

  // Operand decode at the accepting edge; magnitude of 0x80000000 stays 0x80000000.
  always_comb begin
    in_signed   = ~I_op[0];
    a_neg       = in_signed & I_data1[31];
    b_neg       = in_signed & I_data2[31];
    a_mag       = a_neg ? (~I_data1 + 32'd1) : I_data1;
    b_mag       = b_neg ? (~I_data2 + 32'd1) : I_data2;
    in_special  = (I_data2 == 32'd0) ||
                  (in_signed && (I_data1 == 32'h8000_0000) && (I_data2 == 32'hFFFF_FFFF));
    special_val = 32'd0;
    if (I_data2 == 32'd0) begin
      special_val = I_op[1] ? I_data1 : 32'hFFFF_FFFF;
    end else begin
      special_val = I_op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // Restoring step: partial remainder never exceeds the divisor, so diff[32] is the borrow.
  always_comb begin
    rs     = {rem, quo[31]};
    diff   = rs - {1'b0, dvs};
    result = 32'd0;
    if (special_q) begin
      result = special_val_q;
    end else if (is_rem_q) begin
      result = r_neg ? (~rem + 32'd1) : rem;
    end else begin
      result = q_neg ? (~quo + 32'd1) : quo;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state         <= S_IDLE;
      cnt           <= 5'd0;
      quo           <= 32'd0;
      rem           <= 32'd0;
      dvs           <= 32'd0;
      is_rem_q      <= 1'b0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= 32'd0;
      O_busy        <= 1'b0;
      O_done        <= 1'b0;
      O_data        <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (I_start) begin
            cnt           <= 5'd31;
            quo           <= a_mag;
            rem           <= 32'd0;
            dvs           <= b_mag;
            is_rem_q      <= I_op[1];
            q_neg         <= a_neg ^ b_neg;
            r_neg         <= a_neg;
            special_q     <= in_special;
            special_val_q <= special_val;
            if (EarlyOut && in_special) begin
              state  <= S_DONE;
              O_busy <= 1'b0;
              O_done <= 1'b1;
              O_data <= special_val;
            end else begin
              state  <= S_CALC;
              O_busy <= 1'b1;
              O_done <= 1'b0;
            end
          end else begin
            state  <= S_IDLE;
            O_done <= 1'b0;
          end
        end
        S_CALC: begin
          quo <= {quo[30:0], ~diff[32]};
          rem <= diff[32] ? rs[31:0] : diff[31:0];
          if (cnt == 5'd0) begin
            state <= S_FIXUP;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_FIXUP: begin
          O_data <= result;
          O_busy <= 1'b0;
          O_done <= 1'b1;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: vector table through a scoreboard, plus reset-abort, back-to-back and busy-start sequences.
module tb_div_unit;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_start;
  logic [1:0]  I_op;
  logic [31:0] I_data1;
  logic [31:0] I_data2;
  logic        O_busy;
  logic        O_done;
  logic [31:0] O_data;

  localparam int BaseLat = 34;  // counted from the accepting edge (edge 1) to the edge that raises O_done
`ifdef DIV_EARLY_OUT_EN
  localparam int SpecLat = 1;
`else
  localparam int SpecLat = BaseLat;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          lat;
    string       name;
  } exp_t;

  vec_t vecs[20];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  div_unit dut (
    .I_clk  (I_clk),
    .I_rst  (I_rst),
    .I_start(I_start),
    .I_op   (I_op),
    .I_data1(I_data1),
    .I_data2(I_data2),
    .O_busy (O_busy),
    .O_done (O_done),
    .O_data (O_data)
  );

  always #5 I_clk = ~I_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one start pulse across the next rising edge; returns #1 after that edge.
  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input int lat, input string name, input bit push);
    exp_t e;
    I_start = 1'b1;
    I_op    = op;
    I_data1 = a;
    I_data2 = b;
    if (push) begin
      e.data = exp;
      e.lat  = lat;
      e.name = name;
      sb.push_back(e);
    end
    @(posedge I_clk);
    #1;
    I_start = 1'b0;
  endtask

  task automatic wait_done(input int k0);
    int   k;
    exp_t e;
    k = k0;
    while (!O_done && k < 80) begin
      @(posedge I_clk);
      #1;
      k++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: O_done with empty queue, got %h expected none", O_data);
      return;
    end
    e = sb.pop_front();
    if (!O_done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no O_done, expected O_done within %0d cycles", e.name, e.lat);
    end else begin
      check({e.name, " data"}, O_data, e.data);
      check({e.name, " latency"}, 32'(k), 32'(e.lat));
    end
  endtask

  initial begin
    bit seen;
    vecs[0]  = '{2'd0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[1]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0};
    vecs[3]  = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 1'b0};
    vecs[4]  = '{2'd0, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{2'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1};
    vecs[6]  = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[7]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[8]  = '{2'd1, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0};
    vecs[9]  = '{2'd2, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0};
    vecs[10] = '{2'd0, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    vecs[11] = '{2'd0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0};
    vecs[12] = '{2'd2, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0};
    vecs[13] = '{2'd1, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0};
    vecs[14] = '{2'd0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[15] = '{2'd2, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[16] = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[17] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vecs[18] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b1};
    vecs[19] = '{2'd1, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};

    I_rst   = 1'b1;
    I_start = 1'b0;
    I_op    = 2'd0;
    I_data1 = 32'd0;
    I_data2 = 32'd0;
    repeat (3) @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    check("reset busy", 32'(O_busy), 32'd0);
    check("reset done", 32'(O_done), 32'd0);
    check("reset data", O_data, 32'd0);

    for (int i = 0; i < 20; i++) begin
      @(negedge I_clk);
      drive_start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                  vecs[i].special ? SpecLat : BaseLat, $sformatf("vec%0d", i), 1'b1);
      if (!vecs[i].special) check($sformatf("vec%0d busy", i), 32'(O_busy), 32'd1);
      wait_done(1);
    end

    // Reset at CALC cycle 10, with a start presented during the reset cycle.
    @(negedge I_clk);
    drive_start(2'd1, 32'd100, 32'd7, 32'd0, 0, "abort", 1'b0);
    repeat (10) @(posedge I_clk);
    #1;
    I_rst   = 1'b1;
    I_start = 1'b1;
    @(posedge I_clk);
    #1;
    I_rst   = 1'b0;
    I_start = 1'b0;
    check("abort busy", 32'(O_busy), 32'd0);
    check("abort data", O_data, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (O_done) seen = 1'b1;
      @(posedge I_clk);
      #1;
    end
    check("abort no done", 32'(seen), 32'd0);
    check("abort idle busy", 32'(O_busy), 32'd0);
    @(negedge I_clk);
    drive_start(2'd1, 32'd100, 32'd7, 32'h0000_000E, BaseLat, "after abort", 1'b1);
    wait_done(1);

    // Back-to-back: second start issued in the DONE cycle.
    @(negedge I_clk);
    drive_start(2'd1, 32'd100, 32'd7, 32'h0000_000E, BaseLat, "b2b first", 1'b1);
    wait_done(1);
    drive_start(2'd0, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, BaseLat, "b2b second", 1'b1);
    check("b2b done drop", 32'(O_done), 32'd0);
    check("b2b busy", 32'(O_busy), 32'd1);
    wait_done(1);

    // Start and operand churn while busy must not disturb the running divide.
    @(negedge I_clk);
    drive_start(2'd1, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, BaseLat, "busy start", 1'b1);
    for (int c = 0; c < 5; c++) begin
      I_start = 1'b1;
      I_op    = 2'd2;
      I_data1 = $urandom;
      I_data2 = 32'd1;
      @(posedge I_clk);
      #1;
    end
    I_start = 1'b0;
    check("busy start still busy", 32'(O_busy), 32'd1);
    wait_done(6);
    @(posedge I_clk);
    #1;
    check("idle after done", 32'(O_done), 32'd0);
    check("data held", O_data, 32'h0FFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
